uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Buffered UART transmitter: the sending end of the team's UART link, producing frames that the existing `receive` block decodes. Bytes are accepted over a valid/ready write port into an internal FIFO and serialized on `TXout` as 8N1-style frames, with optional parity. The bit-period divider is internal, so the whole block runs on one system clock with no generated clocks. It sits between a host-side producer and the serial pin.

## Interface
- `CLOCK`, default `` `clk100MHz ``: system clock frequency in Hz.
- `BAUDRATE`, default `` `baud_slow ``: line rate in baud.
- `BITWIDTH`, default `` `bitwidth8 ``: data bits per frame, from 5 to 9.
- `DEPTH`, default 16: FIFO entries. Must be a power of two, at least 2.
- `PARITY`, default 0: 0 is none, 1 is even, 2 is odd.
- Derived: `DIV = CLOCK/BAUDRATE`, clk cycles per bit. Must be at least 2.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `rstn`, in, 1: asynchronous, active-low reset.
- `TXen`, in, 1: permits starting new frames.
- `wrValid`, in, 1: write request.
- `wrData`, in, BITWIDTH: byte to queue.
- `wrReady`, out, 1: FIFO can accept; equals !full.
- `TXout`, out, 1: serial line, idle high.
- `TXbusy`, out, 1: high while a frame is on the line.
- `TXdone`, out, 1: one-cycle pulse when a stop bit ends.
- `fifoCount`, out, $clog2(DEPTH)+1: number of queued entries.

## Operation
- Reset values: `TXout`=1, `TXbusy`=0, `TXdone`=0, `fifoCount`=0, `wrReady`=1, FSM in IDLE, divider=0, FIFO pointers=0.
- FIFO:
  - A push occurs on an edge where `wrValid && wrReady`.
  - Writes with `wrReady`=0 are ignored; data is not captured and the count is unchanged.
  - `wrReady` is combinational from the registered count, so a pop in the same cycle does not free a slot for that cycle's write.
  - Simultaneous push and pop leaves the count unchanged, with both pointers advancing.
  - Pointers wrap modulo DEPTH.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: `TXout`=1. If `TXen` and the FIFO is non-empty, pop into the shift register, clear the divider, and go to START.
  - START: `TXout`=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: `TXout`=shift[0], LSB first. After DIV cycles, shift right and increment the index. After bit BITWIDTH-1, go to PARITY if `PARITY`!=0, else STOP.
  - PARITY: `TXout` = XOR of the data bits (even), or its inverse (odd), for DIV cycles.
  - STOP: `TXout`=1 for DIV cycles. On the last cycle, assert `TXdone`. Then, if `TXen` and the FIFO is non-empty, pop and go directly to START (zero idle gap); otherwise go to IDLE.
- Parity is computed from the popped byte at pop time.
- `TXbusy`=1 in START, DATA, PARITY and STOP.
- `TXen` deassertion mid-frame completes the current frame; no further frame starts until `TXen` returns high.
- `rstn` low mid-frame forces `TXout` high immediately (asynchronously), aborts the frame, and empties the FIFO; queued data is lost.

## Timing
- Write-to-line latency from empty/IDLE: if `wrData` is accepted on edge E, the pop occurs on edge E+1 and `TXout` is low after edge E+1.
- Each bit is exactly DIV clk cycles. A frame is (2+BITWIDTH+(PARITY!=0))·DIV cycles.
- `TXdone` is high during the final clk cycle of STOP, coincident with that cycle's pop decision.
- Back-to-back frames: the next start bit begins on the cycle immediately after the previous stop bit's last cycle.
- Throughput: one word per frame time. The FIFO absorbs bursts up to DEPTH.

## Test plan
Bench parameters: CLOCK=1600, BAUDRATE=100 (DIV=16), BITWIDTH=8, DEPTH=4.

1. Reset mid-frame.
   - Stimulus: push 0x55, drop `rstn` 40 cycles after the start bit begins.
   - Response: `TXout`=1 with no clk edge needed; `fifoCount`=0, `TXbusy`=0. After release, the line stays idle.
2. Single frame.
   - Stimulus: PARITY=0, push 0x55 on edge E.
   - Response: `TXout` low after E+1. Line sequence 0,1,0,1,0,1,0,1,0,1, each held 16 cycles. `TXdone` pulses once, 160 cycles after the start bit begins.
3. Parity.
   - Stimulus: PARITY=1, push 0x96.
   - Response: bits 0,0,1,1,0,1,0,0,1, then parity 0, then stop 1. Frame length 176 cycles.
   - With PARITY=2, the parity bit is 1.
4. Burst, full and back-to-back.
   - Stimulus: with `TXen`=0, push 0x01, 0x02, 0x03, 0x04, 0x05.
   - Response: `wrReady` falls after the 4th push; 0x05 is dropped and `fifoCount`=4.
   - Stimulus: raise `TXen`.
   - Response: four contiguous frames with no idle cycle between them, followed by `fifoCount`=0.
5. `TXen` mid-frame.
   - Stimulus: push 0xA5 and 0x3C, then drop `TXen` during the first frame's DATA state.
   - Response: the first frame completes, the line idles and `fifoCount`=1. The second frame starts 1 cycle after `TXen` is raised.
6. Loopback.
   - Stimulus: connect `TXout` to the existing `receive` path and send 0x55 and 0x96.
   - Response: `RXout` matches each byte, `RXerror`=0.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// Buffered UART transmitter. Words written over a valid/ready port are queued
// in an internal FIFO and sent on TXout as frames: one start bit (0),
// BITWIDTH data bits LSB first, an optional parity bit and one stop bit (1).
// Every bit lasts DIV = CLOCK/BAUDRATE clk cycles; no generated clocks.
//
// Ports
//   clk       in   system clock, rising edge
//   rstn      in   asynchronous active-low reset (line forced idle, FIFO emptied)
//   TXen      in   permits new frames to start
//   wrValid   in   write request
//   wrData    in   [BITWIDTH-1:0] word to queue
//   wrReady   out  FIFO can accept (not full)
//   TXout     out  serial line, idle high
//   TXbusy    out  high while a frame is on the line
//   TXdone    out  high during the last cycle of a stop bit
//   fifoCount out  [$clog2(DEPTH):0] number of queued entries
module uart_tx_buffered #(
  parameter int CLOCK    = 100_000_000,
  parameter int BAUDRATE = 9600,
  parameter int BITWIDTH = 8,
  parameter int DEPTH    = 16,
  parameter int PARITY   = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      TXen,
  input  logic                      wrValid,
  input  logic [BITWIDTH-1:0]       wrData,
  output logic                      wrReady,
  output logic                      TXout,
  output logic                      TXbusy,
  output logic                      TXdone,
  output logic [$clog2(DEPTH):0]    fifoCount
);

  localparam int DIV   = CLOCK / BAUDRATE;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int IDX_W = $clog2(BITWIDTH);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITWIDTH - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity bit for a word: even parity is the XOR of the data bits, odd is its inverse.
  function automatic logic parity_bit(input logic [BITWIDTH-1:0] data);
    logic odd;
    odd = (PARITY == 2) ? 1'b1 : 1'b0;
    return (^data) ^ odd;
  endfunction

  // FIFO storage and bookkeeping
  logic [BITWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [AW-1:0]       rptr_q, rptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                full_s, empty_s, push_s, pop_s, can_start_s;

  // Frame engine
  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BITWIDTH-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                bit_end_s;

  // Registered outputs
  logic                txout_q, txout_d;
  logic                txbusy_q, txbusy_d;
  logic                txdone_q, txdone_d;

  assign full_s      = (count_q == CNT_FULL);
  assign empty_s     = (count_q == {CW{1'b0}});
  // wrReady comes from the registered count only: a same-cycle pop frees nothing.
  assign push_s      = wrValid && !full_s;
  assign can_start_s = TXen && !empty_s;
  assign bit_end_s   = (div_q == DIV_LAST);

  assign wrReady   = !full_s;
  assign TXout     = txout_q;
  assign TXbusy    = txbusy_q;
  assign TXdone    = txdone_q;
  assign fifoCount = count_q;

  // FIFO data array: written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= wrData;
    end
  end

  // State register: FSM, divider, shifter, FIFO pointers and the registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      div_q    <= {DIV_W{1'b0}};
      idx_q    <= {IDX_W{1'b0}};
      shift_q  <= {BITWIDTH{1'b0}};
      par_q    <= 1'b0;
      wptr_q   <= {AW{1'b0}};
      rptr_q   <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      txout_q  <= 1'b1;
      txbusy_q <= 1'b0;
      txdone_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      txout_q  <= txout_d;
      txbusy_q <= txbusy_d;
      txdone_q <= txdone_d;
    end
  end

  // Next-state logic: frame sequencing, pop decision and FIFO pointer/count update.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (can_start_s) begin
          pop_s   = 1'b1;
          state_d = S_START;
          div_d   = {DIV_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          div_d   = {DIV_W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          state_d = S_DATA;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          div_d   = {DIV_W{1'b0}};
          shift_d = {1'b0, shift_q[BITWIDTH-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          div_d   = {DIV_W{1'b0}};
          state_d = S_STOP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          div_d = {DIV_W{1'b0}};
          // Chaining straight into START keeps back-to-back frames gap-free.
          if (can_start_s) begin
            pop_s   = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        div_d   = {DIV_W{1'b0}};
      end
    endcase

    // A popped word is loaded with its parity precomputed.
    if (pop_s) begin
      shift_d = mem_q[rptr_q];
      par_d   = parity_bit(mem_q[rptr_q]);
    end else begin
      par_d = par_d;
    end

    wptr_d = push_s ? (wptr_q + AW'(1)) : wptr_q;
    rptr_d = pop_s  ? (rptr_q + AW'(1)) : rptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Output logic: line level, busy and done derived from the next state so they register cleanly.
  always_comb begin
    txout_d  = 1'b1;
    txbusy_d = (state_d != S_IDLE);
    txdone_d = (state_d == S_STOP) && (div_d == DIV_LAST);
    case (state_d)
      S_IDLE:   txout_d = 1'b1;
      S_START:  txout_d = 1'b0;
      S_DATA:   txout_d = shift_d[0];
      S_PARITY: txout_d = par_d;
      S_STOP:   txout_d = 1'b1;
      default:  txout_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three instances (no, even, odd parity) share
// stimulus. A queue-based reference model builds each expected frame as a
// per-cycle line waveform from the frame format and is compared every cycle.
module tb_uart_tx_buffered;

  localparam int CLOCK    = 1600;
  localparam int BAUDRATE = 100;
  localparam int DIV      = CLOCK / BAUDRATE;
  localparam int BITWIDTH = 8;
  localparam int DEPTH    = 4;
  localparam int NDUT     = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       TXen = 1'b0;
  logic       wrValid = 1'b0;
  logic [7:0] wrData = 8'h00;

  logic       wr_ready_s [NDUT];
  logic       tx_out_s   [NDUT];
  logic       tx_busy_s  [NDUT];
  logic       tx_done_s  [NDUT];
  logic [2:0] fifo_cnt_s [NDUT];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state per instance: queued words and remaining line cycles.
  logic [7:0] mq [NDUT][$];
  bit         mw [NDUT][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_tx_buffered #(
      .CLOCK(CLOCK), .BAUDRATE(BAUDRATE), .BITWIDTH(BITWIDTH),
      .DEPTH(DEPTH), .PARITY(g)
    ) u_dut (
      .clk(clk), .rstn(rstn), .TXen(TXen), .wrValid(wrValid), .wrData(wrData),
      .wrReady(wr_ready_s[g]), .TXout(tx_out_s[g]), .TXbusy(tx_busy_s[g]),
      .TXdone(tx_done_s[g]), .fifoCount(fifo_cnt_s[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line for one frame: start, data LSB first, optional parity, stop; each DIV cycles.
  task automatic build_frame(input int d, input logic [7:0] data);
    bit bits [$];
    int ones;
    bits.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < BITWIDTH; i++) begin
      bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (d == 1) bits.push_back((ones % 2) == 1);
    if (d == 2) bits.push_back((ones % 2) == 0);
    bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int c = 0; c < DIV; c++) mw[d].push_back(bits[k]);
    end
  endtask

  // One clock edge of the reference model, using the inputs held before the edge.
  task automatic model_step(input int d);
    bit accept, had_data;
    if (!rstn) begin
      mq[d].delete();
      mw[d].delete();
      return;
    end
    accept   = wrValid && (mq[d].size() < DEPTH);
    had_data = (mq[d].size() > 0);
    if (mw[d].size() > 0) void'(mw[d].pop_front());
    if (mw[d].size() == 0 && TXen && had_data) build_frame(d, mq[d].pop_front());
    if (accept) mq[d].push_back(wrData);
  endtask

  task automatic compare_all();
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("p%0d_txout", d), 32'(tx_out_s[d]),
               (mw[d].size() > 0) ? 32'(mw[d][0]) : 32'd1);
      check_eq($sformatf("p%0d_busy", d), 32'(tx_busy_s[d]), 32'(mw[d].size() > 0));
      check_eq($sformatf("p%0d_done", d), 32'(tx_done_s[d]), 32'(mw[d].size() == 1));
      check_eq($sformatf("p%0d_count", d), 32'(fifo_cnt_s[d]), 32'(mq[d].size()));
      check_eq($sformatf("p%0d_ready", d), 32'(wr_ready_s[d]), 32'(mq[d].size() < DEPTH));
    end
  endtask

  // Advance one cycle: model on the rising edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) model_step(d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic push(input logic [7:0] b);
    wrValid = 1'b1;
    wrData  = b;
    tick();
    wrValid = 1'b0;
  endtask

  function automatic bit model_busy();
    for (int d = 0; d < NDUT; d++) begin
      if (mw[d].size() > 0 || (TXen && mq[d].size() > 0)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (model_busy() && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(n >= budget), 32'd0);
  endtask

  initial begin
    int idle_ticks;

    // Reset state
    repeat (3) tick();
    rstn = 1'b1;
    repeat (3) tick();
    check_eq("reset_txout", 32'(tx_out_s[0]), 32'd1);
    check_eq("reset_count", 32'(fifo_cnt_s[0]), 32'd0);

    // Single frame and parity variants: 0x55 then 0x96 on all three instances
    TXen = 1'b1;
    push(8'h55);
    tick();
    check_eq("start_low_after_e1", 32'(tx_out_s[0]), 32'd0);
    drain("drain_55", 400);
    push(8'h96);
    drain("drain_96", 400);
    repeat (5) tick();

    // Burst into a stopped transmitter: fifth word must be dropped
    TXen = 1'b0;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    check_eq("burst_ready_low", 32'(wr_ready_s[0]), 32'd0);
    push(8'h05);
    check_eq("burst_count", 32'(fifo_cnt_s[0]), 32'd4);
    TXen = 1'b1;
    drain("drain_burst", 1200);
    check_eq("burst_empty", 32'(fifo_cnt_s[0]), 32'd0);

    // TXen dropped mid-frame: frame finishes, second word waits
    push(8'hA5);
    push(8'h3C);
    repeat (60) tick();
    TXen = 1'b0;
    drain("drain_txen", 400);
    repeat (10) tick();
    check_eq("txen_hold_count", 32'(fifo_cnt_s[0]), 32'd1);
    check_eq("txen_hold_idle", 32'(tx_out_s[0]), 32'd1);
    TXen = 1'b1;
    tick();
    check_eq("txen_resume_start", 32'(tx_out_s[0]), 32'd0);
    drain("drain_resume", 400);

    // Randomized traffic with occasional TXen toggles
    for (int i = 0; i < 4000; i++) begin
      wrValid = ($urandom_range(0, 3) == 0);
      wrData  = 8'($urandom);
      if ($urandom_range(0, 199) == 0) TXen = ~TXen;
      tick();
    end
    wrValid = 1'b0;
    TXen    = 1'b1;
    drain("drain_random", 1500);

    // Reset mid-frame: line must go idle without a clock edge
    push(8'h55);
    repeat (41) tick();
    check_eq("pre_reset_busy", 32'(tx_busy_s[0]), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("async_txout", 32'(tx_out_s[0]), 32'd1);
    check_eq("async_count", 32'(fifo_cnt_s[0]), 32'd0);
    check_eq("async_busy", 32'(tx_busy_s[0]), 32'd0);
    for (int d = 0; d < NDUT; d++) begin
      mq[d].delete();
      mw[d].delete();
    end
    @(negedge clk);
    repeat (4) tick();
    rstn = 1'b1;
    idle_ticks = 0;
    repeat (50) begin
      tick();
      if (tx_out_s[0] === 1'b1) idle_ticks++;
    end
    check_eq("post_reset_idle", 32'(idle_ticks), 32'd50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
